// File: rtl/narrow_out_txn_limiter_pkg.sv
// rtl/narrow_out_txn_limiter_pkg.sv - response codes and error classification for the limiter
package txn_limiter_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR are the only codes that count as errors.
  function automatic logic is_err_resp(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/snitch_cluster_pkg.sv
// rtl/snitch_cluster_pkg.sv - narrow AXI request/response types of the cluster
package snitch_cluster_pkg;

  localparam int unsigned NarrowIdWidth   = 4;
  localparam int unsigned NarrowAddrWidth = 48;
  localparam int unsigned NarrowDataWidth = 64;

  typedef struct packed {
    logic [NarrowIdWidth-1:0]   id;
    logic [NarrowAddrWidth-1:0] addr;
    logic [7:0]                 len;
    logic [2:0]                 size;
    logic [1:0]                 burst;
  } narrow_ax_chan_t;

  typedef struct packed {
    logic [NarrowDataWidth-1:0]   data;
    logic [NarrowDataWidth/8-1:0] strb;
    logic                         last;
  } narrow_w_chan_t;

  typedef struct packed {
    logic [NarrowIdWidth-1:0] id;
    logic [1:0]               resp;
  } narrow_b_chan_t;

  typedef struct packed {
    logic [NarrowIdWidth-1:0]   id;
    logic [NarrowDataWidth-1:0] data;
    logic [1:0]                 resp;
    logic                       last;
  } narrow_r_chan_t;

  typedef struct packed {
    narrow_ax_chan_t aw;
    logic            aw_valid;
    narrow_w_chan_t  w;
    logic            w_valid;
    logic            b_ready;
    narrow_ax_chan_t ar;
    logic            ar_valid;
    logic            r_ready;
  } narrow_out_req_t;

  typedef struct packed {
    logic           aw_ready;
    logic           ar_ready;
    logic           w_ready;
    logic           b_valid;
    narrow_b_chan_t b;
    logic           r_valid;
    narrow_r_chan_t r;
  } narrow_out_resp_t;

endpackage

// File: rtl/narrow_out_txn_limiter_txn_counter.sv
// rtl/narrow_out_txn_limiter_txn_counter.sv - outstanding-transaction counter with valid-stability lock
module txn_counter #(
  parameter int unsigned Max  = 8,
  parameter int unsigned CntW = $clog2(Max + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_i,
  input  logic            dec_i,
  input  logic            lock_set_i,
  input  logic            lock_clr_i,
  input  logic            drain_i,
  output logic            allow_o,
  output logic            lock_o,
  output logic [CntW-1:0] count_o,
  output logic            underflow_o
);

  localparam logic [CntW-1:0] MaxC = CntW'(Max);

  logic [CntW-1:0] r_count;
  logic            r_lock;

  // Admission looks at registered state only, so a same-cycle decrement never frees a slot early.
  assign allow_o     = r_lock | ((r_count < MaxC) & ~drain_i);
  assign lock_o      = r_lock;
  assign count_o     = r_count;
  assign underflow_o = dec_i & ~inc_i & (r_count == '0);

  // Count up on request handshake, down on completion; simultaneous events cancel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (inc_i && !dec_i) begin
      r_count <= r_count + CntW'(1);
    end else if (dec_i && !inc_i && (r_count != '0)) begin
      r_count <= r_count - CntW'(1);
    end
  end

  // Hold admission open while a presented request waits for ready, so valid is never withdrawn.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock <= 1'b0;
    end else if (lock_clr_i) begin
      r_lock <= 1'b0;
    end else if (lock_set_i) begin
      r_lock <= 1'b1;
    end
  end

endmodule

// File: rtl/narrow_out_txn_limiter.sv
// rtl/narrow_out_txn_limiter.sv - caps outstanding narrow AXI reads/writes, drains, counts errors
module narrow_out_txn_limiter
  import snitch_cluster_pkg::*;
  import txn_limiter_pkg::*;
#(
  parameter int unsigned MaxReads    = 8,
  parameter int unsigned MaxWrites   = 8,
  parameter int unsigned ErrCntWidth = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  narrow_out_req_t                  slv_req_i,
  output narrow_out_resp_t                 slv_resp_o,
  output narrow_out_req_t                  mst_req_o,
  input  narrow_out_resp_t                 mst_resp_i,
  input  logic                             drain_i,
  output logic                             idle_o,
  output logic [$clog2(MaxReads+1)-1:0]    rd_cnt_o,
  output logic [$clog2(MaxWrites+1)-1:0]   wr_cnt_o,
  output logic [ErrCntWidth-1:0]           err_cnt_o,
  input  logic                             err_clr_i,
  output logic                             proto_err_o
);

  logic w_allow_ar, w_allow_aw;
  logic w_ar_lock, w_aw_lock;
  logic w_ar_valid, w_aw_valid;
  logic w_ar_hs, w_aw_hs, w_ar_stall, w_aw_stall;
  logic w_r_last_hs, w_b_hs;
  logic w_rd_uf, w_wr_uf;
  logic w_r_err, w_b_err;
  logic [1:0]             w_err_inc;
  logic [ErrCntWidth:0]   w_err_sum;
  logic [ErrCntWidth-1:0] r_err_cnt;
  logic                   r_proto_err;

  assign w_ar_valid  = slv_req_i.ar_valid & w_allow_ar;
  assign w_aw_valid  = slv_req_i.aw_valid & w_allow_aw;
  assign w_ar_hs     = w_ar_valid & mst_resp_i.ar_ready;
  assign w_aw_hs     = w_aw_valid & mst_resp_i.aw_ready;
  assign w_ar_stall  = w_ar_valid & ~mst_resp_i.ar_ready;
  assign w_aw_stall  = w_aw_valid & ~mst_resp_i.aw_ready;
  assign w_r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign w_b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;

  // Everything passes straight through except the two address-channel handshakes.
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = w_ar_valid;
    mst_req_o.aw_valid = w_aw_valid;
  end

  // Ready back to the cluster is masked the same way so no handshake happens on a blocked request.
  always_comb begin
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & w_allow_ar;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & w_allow_aw;
  end

  txn_counter #(.Max(MaxReads)) i_rd_counter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (w_ar_hs),
    .dec_i       (w_r_last_hs),
    .lock_set_i  (w_ar_stall),
    .lock_clr_i  (w_ar_hs),
    .drain_i     (drain_i),
    .allow_o     (w_allow_ar),
    .lock_o      (w_ar_lock),
    .count_o     (rd_cnt_o),
    .underflow_o (w_rd_uf)
  );

  txn_counter #(.Max(MaxWrites)) i_wr_counter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (w_aw_hs),
    .dec_i       (w_b_hs),
    .lock_set_i  (w_aw_stall),
    .lock_clr_i  (w_aw_hs),
    .drain_i     (drain_i),
    .allow_o     (w_allow_aw),
    .lock_o      (w_aw_lock),
    .count_o     (wr_cnt_o),
    .underflow_o (w_wr_uf)
  );

  assign idle_o = (rd_cnt_o == '0) & (wr_cnt_o == '0) & ~w_ar_lock & ~w_aw_lock;

  // A completion with nothing outstanding means the downstream broke protocol; remember it until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_proto_err <= 1'b0;
    end else if (w_rd_uf || w_wr_uf) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err_o = r_proto_err;

  // Only the final R beat carries the transaction's status, so non-last beats are ignored.
  assign w_r_err   = w_r_last_hs & is_err_resp(mst_resp_i.r.resp);
  assign w_b_err   = w_b_hs & is_err_resp(mst_resp_i.b.resp);
  assign w_err_inc = {1'b0, w_r_err} + {1'b0, w_b_err};
  assign w_err_sum = {1'b0, r_err_cnt} + {{(ErrCntWidth-1){1'b0}}, w_err_inc};

  // Saturating error counter; clear wins over events in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || err_clr_i) begin
      r_err_cnt <= '0;
    end else if (w_err_sum[ErrCntWidth]) begin
      r_err_cnt <= '1;
    end else begin
      r_err_cnt <= w_err_sum[ErrCntWidth-1:0];
    end
  end

  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_narrow_out_txn_limiter.sv
// tb/tb_narrow_out_txn_limiter.sv - directed self-checking bench for narrow_out_txn_limiter
module tb_narrow_out_txn_limiter;
  import snitch_cluster_pkg::*;

  logic             clk;
  logic             rst;
  narrow_out_req_t  slv_req;
  narrow_out_resp_t slv_resp;
  narrow_out_req_t  mst_req;
  narrow_out_resp_t mst_resp;
  logic             drain;
  logic             idle;
  logic [3:0]       rd_cnt;
  logic [3:0]       wr_cnt;
  logic [15:0]      err_cnt;
  logic             err_clr;
  logic             proto_err;

  int n_tests = 0;
  int n_fail  = 0;
  int hs;

  narrow_out_txn_limiter #(.MaxReads(8), .MaxWrites(8), .ErrCntWidth(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .slv_req_i   (slv_req),
    .slv_resp_o  (slv_resp),
    .mst_req_o   (mst_req),
    .mst_resp_i  (mst_resp),
    .drain_i     (drain),
    .idle_o      (idle),
    .rd_cnt_o    (rd_cnt),
    .wr_cnt_o    (wr_cnt),
    .err_cnt_o   (err_cnt),
    .err_clr_i   (err_clr),
    .proto_err_o (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("rd_cnt_le_max", 32'(rd_cnt <= 4'd8), 32'd1);
    chk("wr_cnt_le_max", 32'(wr_cnt <= 4'd8), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    slv_req  = '0;
    mst_resp = '0;
    drain    = 1'b0;
    err_clr  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    slv_req.w.data = 64'h0000_0000_1234_5678;
    #1;
    chk("reset_rd_cnt", 32'(rd_cnt), 0);
    chk("reset_wr_cnt", 32'(wr_cnt), 0);
    chk("reset_err_cnt", 32'(err_cnt), 0);
    chk("reset_proto_err", 32'(proto_err), 0);
    chk("reset_idle", 32'(idle), 1);
    chk("w_passthrough", mst_req.w.data[31:0], 32'h1234_5678);

    // Fill reads to the cap with R held off
    slv_req.r_ready = 1'b1;
    slv_req.b_ready = 1'b1;
    slv_req.ar_valid = 1'b1;
    mst_resp.ar_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (mst_req.ar_valid && mst_resp.ar_ready) hs++;
      tick();
    end
    #1;
    chk("ar_handshakes", 32'(hs), 8);
    chk("rd_cnt_full", 32'(rd_cnt), 8);
    chk("ar9_mst_valid", 32'(mst_req.ar_valid), 0);
    chk("ar9_slv_ready", 32'(slv_resp.ar_ready), 0);
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    #1;
    chk("ar_blocked_with_rlast", 32'(mst_req.ar_valid), 0);
    tick();
    mst_resp.r_valid = 1'b0;
    #1;
    chk("rd_cnt_after_rlast", 32'(rd_cnt), 7);
    chk("ar9_released", 32'(mst_req.ar_valid), 1);
    tick();
    slv_req.ar_valid = 1'b0;
    #1;
    chk("rd_cnt_refull", 32'(rd_cnt), 8);
    mst_resp.r_valid = 1'b1;
    repeat (8) tick();
    mst_resp.r_valid = 1'b0;
    #1;
    chk("rd_cnt_drained", 32'(rd_cnt), 0);

    // Writes at the cap with simultaneous B and pending AW
    slv_req.aw_valid = 1'b1;
    mst_resp.aw_ready = 1'b1;
    repeat (8) tick();
    #1;
    chk("wr_cnt_full", 32'(wr_cnt), 8);
    mst_resp.b_valid = 1'b1;
    #1;
    chk("aw_blocked_with_b", 32'(mst_req.aw_valid), 0);
    tick();
    mst_resp.b_valid = 1'b0;
    #1;
    chk("wr_cnt_after_b", 32'(wr_cnt), 7);
    chk("aw_released", 32'(mst_req.aw_valid), 1);
    tick();
    slv_req.aw_valid = 1'b0;
    #1;
    chk("wr_cnt_refull", 32'(wr_cnt), 8);
    mst_resp.b_valid = 1'b1;
    repeat (8) tick();
    mst_resp.b_valid = 1'b0;
    #1;
    chk("wr_cnt_drained", 32'(wr_cnt), 0);

    // Lock keeps a presented AR valid across drain
    slv_req.ar_valid = 1'b1;
    mst_resp.ar_ready = 1'b0;
    #1;
    chk("ar_presented", 32'(mst_req.ar_valid), 1);
    tick();
    drain = 1'b1;
    #1;
    chk("ar_lock_hold", 32'(mst_req.ar_valid), 1);
    chk("not_idle_locked", 32'(idle), 0);
    tick();
    chk("ar_lock_hold2", 32'(mst_req.ar_valid), 1);
    mst_resp.ar_ready = 1'b1;
    tick();
    #1;
    chk("rd_cnt_lock_hs", 32'(rd_cnt), 1);
    chk("ar_drain_block", 32'(mst_req.ar_valid), 0);
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1;
    tick();
    mst_resp.r_valid = 1'b0;
    #1;
    chk("idle_after_drain", 32'(idle), 1);
    drain = 1'b0;

    // Error counting
    slv_req.ar_valid = 1'b1;
    repeat (3) tick();
    slv_req.ar_valid = 1'b0;
    slv_req.aw_valid = 1'b1;
    repeat (2) tick();
    slv_req.aw_valid = 1'b0;
    #1;
    chk("err_rd_out", 32'(rd_cnt), 3);
    chk("err_wr_out", 32'(wr_cnt), 2);
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b0;
    mst_resp.r.resp  = 2'b11;
    tick();
    mst_resp.r.last  = 1'b1;
    mst_resp.r.resp  = 2'b10;
    repeat (3) tick();
    mst_resp.r_valid = 1'b0;
    mst_resp.r.resp  = 2'b00;
    mst_resp.b_valid = 1'b1;
    mst_resp.b.resp  = 2'b11;
    repeat (2) tick();
    mst_resp.b_valid = 1'b0;
    #1;
    chk("err_cnt_5", 32'(err_cnt), 5);
    chk("err_rd_zero", 32'(rd_cnt), 0);
    chk("err_wr_zero", 32'(wr_cnt), 0);
    slv_req.ar_valid = 1'b1;
    slv_req.aw_valid = 1'b1;
    tick();
    slv_req.ar_valid = 1'b0;
    slv_req.aw_valid = 1'b0;
    mst_resp.r_valid = 1'b1;
    mst_resp.r.resp  = 2'b10;
    mst_resp.b_valid = 1'b1;
    mst_resp.b.resp  = 2'b10;
    tick();
    mst_resp.r_valid = 1'b0;
    mst_resp.b_valid = 1'b0;
    #1;
    chk("err_cnt_dual", 32'(err_cnt), 7);
    slv_req.aw_valid = 1'b1;
    tick();
    slv_req.aw_valid = 1'b0;
    err_clr = 1'b1;
    mst_resp.b_valid = 1'b1;
    mst_resp.b.resp  = 2'b11;
    tick();
    err_clr = 1'b0;
    mst_resp.b_valid = 1'b0;
    #1;
    chk("err_clr_priority", 32'(err_cnt), 0);
    chk("err_clr_wr_cnt", 32'(wr_cnt), 0);
    chk("no_proto_err_yet", 32'(proto_err), 0);

    // Underflow
    mst_resp.b_valid = 1'b1;
    mst_resp.b.resp  = 2'b00;
    tick();
    mst_resp.b_valid = 1'b0;
    #1;
    chk("proto_err_set", 32'(proto_err), 1);
    chk("uf_wr_cnt", 32'(wr_cnt), 0);
    tick();
    chk("proto_err_sticky", 32'(proto_err), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("proto_err_reset", 32'(proto_err), 0);

    // Reset with traffic outstanding
    slv_req.ar_valid = 1'b1;
    repeat (3) tick();
    slv_req.ar_valid = 1'b0;
    slv_req.aw_valid = 1'b1;
    repeat (3) tick();
    slv_req.aw_valid = 1'b0;
    mst_resp.b_valid = 1'b1;
    mst_resp.b.resp  = 2'b10;
    tick();
    mst_resp.b_valid = 1'b0;
    #1;
    chk("pre_rst_rd", 32'(rd_cnt), 3);
    chk("pre_rst_wr", 32'(wr_cnt), 2);
    chk("pre_rst_err", 32'(err_cnt), 1);
    chk("pre_rst_idle", 32'(idle), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_rd", 32'(rd_cnt), 0);
    chk("post_rst_wr", 32'(wr_cnt), 0);
    chk("post_rst_err", 32'(err_cnt), 0);
    chk("post_rst_idle", 32'(idle), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/narrow_out_txn_limiter.md
Name: narrow_out_txn_limiter

Overview:
- Sits between the cluster's narrow AXI master port (narrow_out_req/narrow_out_resp) and the narrow NoC chimney slave port.
- Caps outstanding read and write transactions per direction, and drains on request for clean power-down or reconfiguration.
- Counts error responses. W, R and B data pass through unchanged.

Parameters:
- MaxReads, 8, max outstanding AR transactions (1..255).
- MaxWrites, 8, max outstanding AW transactions (1..255).
- ErrCntWidth, 16, width of saturating error counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- slv_req_i  in  narrow_out_req_t  requests from cluster.
- slv_resp_o  out  narrow_out_resp_t  responses to cluster.
- mst_req_o  out  narrow_out_req_t  requests to chimney.
- mst_resp_i  in  narrow_out_resp_t  responses from chimney.
- drain_i  in  1  block new AR/AW while high.
- idle_o  out  1  both counters zero and no AR/AW valid pending downstream.
- rd_cnt_o  out  $clog2(MaxReads+1)  outstanding reads.
- wr_cnt_o  out  $clog2(MaxWrites+1)  outstanding writes.
- err_cnt_o  out  ErrCntWidth  error responses seen.
- err_clr_i  in  1  clear err_cnt_o.
- proto_err_o  out  1  sticky: response with zero outstanding.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: all counters 0, proto_err_o=0, ar_lock/aw_lock=0. idle_o=1 after reset when inputs are idle. mst_req_o valids follow the gating below.
- Pass-through: all fields, W channel, R/B channels and their ready/valid are combinational wires. Zero latency, no registers in the data path.
- AR gating:
  - allow_ar = ar_lock | ((rd_cnt < MaxReads) & ~drain_i).
  - mst.ar_valid = slv.ar_valid & allow_ar; slv.ar_ready = mst.ar_ready & allow_ar.
- AR lock (AXI valid stability):
  - ar_lock sets when mst.ar_valid=1 and mst.ar_ready=0.
  - It clears on the AR handshake.
  - A presented AR is therefore never withdrawn by drain_i or counter changes.
- AW: same gating with wr_cnt, MaxWrites and aw_lock.
- rd_cnt: +1 on AR handshake; -1 on R handshake with r.last.
  - Both in the same cycle: unchanged.
  - The decision uses the registered count only. At MaxReads with a simultaneous R-last, no new AR is accepted that cycle.
- wr_cnt: +1 on AW handshake; -1 on B handshake. Same simultaneous-event rule as rd_cnt.
- Underflow: decrement event with count 0 and no same-cycle increment.
  - Count stays 0 and proto_err_o sets.
  - proto_err_o clears only on reset.
- Overflow cannot occur by construction; the bench asserts count never exceeds its maximum.
- err_cnt:
  - +1 per R-last handshake with resp[1]=1, +1 per B handshake with resp[1]=1 (SLVERR/DECERR).
  - +2 if both occur in the same cycle.
  - Saturates at all-ones.
  - err_clr_i has priority: counter goes to 0, and same-cycle events are dropped.
- Non-last R beats with an error are not counted.
- idle_o = (rd_cnt==0) & (wr_cnt==0) & ~ar_lock & ~aw_lock, registered-state only.
- W beats are not gated. The cluster may send W ahead of AW; the chimney handles ordering.
- Reset mid-operation: all state returns to reset values; in-flight transactions are discarded. rst_i must be applied to the whole narrow path together.

Decomposition:
- narrow_out_req_t / narrow_out_resp_t come from snitch_cluster_pkg, imported unchanged.
- A small package, txn_limiter_pkg, holds the response-code constants (RESP_SLVERR=2'b10, RESP_DECERR=2'b11).
- One sub-module is natural: txn_counter (parameterised Max).
  - Inputs: inc, dec, lock-set/clear, drain.
  - Outputs: allow, count, underflow.
  - Instantiated twice, for read and write.

Test Plan:
- MaxReads=8: issue 10 ARs back-to-back with R held off -> 8 handshakes, rd_cnt_o=8, 9th AR stalled with mst ar_valid=0. Return one R-last -> 9th AR accepted the next cycle.
- At wr_cnt=8, B handshake and pending AW in the same cycle -> AW not accepted that cycle, wr_cnt_o=7, AW accepted next cycle, wr_cnt_o back to 8.
- AR presented with ar_ready=0, then drain_i=1 -> mst ar_valid stays 1 until handshake; next AR blocked. After all R-last beats return -> idle_o=1.
- 3 R-last SLVERR, 1 non-last DECERR beat, 2 B DECERR -> err_cnt_o=5. Pulse err_clr_i with a same-cycle B error -> err_cnt_o=0.
- B handshake with wr_cnt=0 -> proto_err_o=1 and stays, wr_cnt_o=0. Assert rst_i -> proto_err_o=0.
- 3 reads and 2 writes outstanding, assert rst_i for 1 cycle -> rd_cnt_o=0, wr_cnt_o=0, err_cnt_o=0, idle_o=1 the next cycle.
